// File: rtl/score_bcd_tracker.sv
// Snake-game score keeper: 4-digit BCD score with saturation, session high score,
// and selection of the value handed to the SSD scanner (blinking score/high in OVER).
module score_bcd_tracker #(
    parameter int POINTS_PER_FOOD = 1,
    parameter int BLINK_DIV       = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       eat,
    input  logic       game_over,
    input  logic       new_game,
    input  logic       show_high,
    output logic [3:0] b0,
    output logic [3:0] b1,
    output logic [3:0] b2,
    output logic [3:0] b3,
    output logic       disp_en
);

    localparam int CW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   score;
    logic [15:0]   high;
    logic [CW-1:0] blink_cnt;
    logic          blink_sel;

    logic [15:0]   inc_score;
    logic [15:0]   next_score;
    logic [4:0]    addend;
    logic [4:0]    dsum;
    logic [15:0]   src;

    // Ripple the points through the four decimal digits; a carry out of the
    // thousands digit means the true sum passed 9999, so clamp there.
    always_comb begin
        inc_score = '0;
        addend    = 5'(POINTS_PER_FOOD);
        dsum      = '0;
        for (int i = 0; i < 4; i++) begin
            dsum = {1'b0, score[4*i +: 4]} + addend;
            if (dsum > 5'd9) begin
                inc_score[4*i +: 4] = 4'(dsum - 5'd10);
                addend              = 5'd1;
            end else begin
                inc_score[4*i +: 4] = dsum[3:0];
                addend              = 5'd0;
            end
        end
        next_score = (addend != 5'd0) ? 16'h9999 : inc_score;
    end

    always_comb begin
        src = score;
        if (state == OVER) begin
            src = blink_sel ? high : score;
        end else if (show_high) begin
            src = high;
        end
    end

    // Packed BCD compares in the same order as a most-significant-digit-first
    // decimal compare. Score is frozen in OVER, so refreshing high on every
    // OVER edge gives the same result as updating only on the first one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            score     <= '0;
            high      <= '0;
            blink_cnt <= '0;
            blink_sel <= 1'b0;
            b0        <= '0;
            b1        <= '0;
            b2        <= '0;
            b3        <= '0;
            disp_en   <= 1'b0;
        end else begin
            disp_en <= 1'b1;
            b0      <= src[3:0];
            b1      <= src[7:4];
            b2      <= src[11:8];
            b3      <= src[15:12];

            case (state)
                IDLE: begin
                    if (new_game) begin
                        state <= PLAY;
                        score <= '0;
                    end
                end
                PLAY: begin
                    if (new_game) begin
                        score <= '0;
                    end else begin
                        if (eat) begin
                            score <= next_score;
                        end
                        if (game_over) begin
                            state <= OVER;
                        end
                    end
                end
                OVER: begin
                    high <= (score > high) ? score : high;
                    if (new_game) begin
                        state <= PLAY;
                        score <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (state == OVER && !new_game) begin
                if (blink_cnt == CW'(BLINK_DIV - 1)) begin
                    blink_cnt <= '0;
                    blink_sel <= ~blink_sel;
                end else begin
                    blink_cnt <= blink_cnt + CW'(1);
                end
            end else begin
                blink_cnt <= '0;
                blink_sel <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_tracker.sv
// Scoreboard bench for score_bcd_tracker: two instances (1 and 7 points per food)
// share stimulus and are checked against a decimal-arithmetic reference model.
module tb_score_bcd_tracker;

    localparam int BLINK = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic eat = 1'b0;
    logic game_over = 1'b0;
    logic new_game = 1'b0;
    logic show_high = 1'b0;

    logic [3:0] a0, a1, a2, a3;
    logic [3:0] c0, c1, c2, c3;
    logic       a_en, c_en;

    score_bcd_tracker #(.POINTS_PER_FOOD(1), .BLINK_DIV(BLINK)) dut_p1 (
        .clk(clk), .rst(rst), .eat(eat), .game_over(game_over),
        .new_game(new_game), .show_high(show_high),
        .b0(a0), .b1(a1), .b2(a2), .b3(a3), .disp_en(a_en)
    );

    score_bcd_tracker #(.POINTS_PER_FOOD(7), .BLINK_DIV(BLINK)) dut_p7 (
        .clk(clk), .rst(rst), .eat(eat), .game_over(game_over),
        .new_game(new_game), .show_high(show_high),
        .b0(c0), .b1(c1), .b2(c2), .b3(c3), .disp_en(c_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] b_p1;
        logic [15:0] b_p7;
        logic        en;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int passed = 0;

    // Reference model: 0 = idle, 1 = playing, 2 = game over
    int m_state = 0;
    int m_score1 = 0, m_score7 = 0;
    int m_high1 = 0, m_high7 = 0;
    int m_t = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int shown(input int sc, input int hi, input logic sh);
        if (m_state == 2) return (((m_t / BLINK) % 2) == 1) ? hi : sc;
        return sh ? hi : sc;
    endfunction

    function automatic int add_sat(input int sc, input int p);
        return (sc + p > 9999) ? 9999 : sc + p;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic g,
                                 input logic n, input logic s);
        exp_t x;
        rst = r; eat = e; game_over = g; new_game = n; show_high = s;
        x.b_p1 = r ? 16'h0 : to_bcd(shown(m_score1, m_high1, s));
        x.b_p7 = r ? 16'h0 : to_bcd(shown(m_score7, m_high7, s));
        x.en   = !r;
        if (r) begin
            m_state = 0; m_score1 = 0; m_score7 = 0;
            m_high1 = 0; m_high7 = 0; m_t = 0;
        end else begin
            case (m_state)
                0: if (n) begin m_state = 1; m_score1 = 0; m_score7 = 0; end
                1: begin
                    if (n) begin
                        m_score1 = 0; m_score7 = 0;
                    end else begin
                        if (e) begin
                            m_score1 = add_sat(m_score1, 1);
                            m_score7 = add_sat(m_score7, 7);
                        end
                        if (g) begin m_state = 2; m_t = 0; end
                    end
                end
                default: begin
                    if (m_score1 > m_high1) m_high1 = m_score1;
                    if (m_score7 > m_high7) m_high7 = m_score7;
                    if (n) begin m_state = 1; m_score1 = 0; m_score7 = 0; end
                    else m_t++;
                end
            endcase
        end
        @(posedge clk);
        sbq.push_back(x);
        #1;
    endtask

    // Monitor: one expected entry per clock edge, compared mid-cycle.
    initial begin
        exp_t y;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                y = sbq.pop_front();
                checkOutput("b_p1", {a3, a2, a1, a0}, y.b_p1);
                checkOutput("b_p7", {c3, c2, c1, c0}, y.b_p7);
                checkOutput("en_p1", {15'h0, a_en}, {15'h0, y.en});
                checkOutput("en_p7", {15'h0, c_en}, {15'h0, y.en});
            end
        end
    end

    initial begin
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        repeat (12) applyStimulus(0, 1, 0, 0, 0);
        repeat (2)  applyStimulus(0, 0, 0, 0, 0);
        repeat (30) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        repeat (12) applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(0, 0, 0, 1, 0);
        repeat (17) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        repeat (18) applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(0, 0, 0, 1, 1);
        repeat (5) applyStimulus(0, 1, 0, 0, 1);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0);

        repeat (1430) applyStimulus(0, 1, 0, 0, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        repeat (10) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 1);

        repeat (3000) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 9) < 4,
                          $urandom_range(0, 49) == 0,
                          $urandom_range(0, 59) == 0,
                          $urandom_range(0, 4) == 0);
        end

        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checkOutput("sb_drain", 16'(sbq.size()), 16'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
